scr1_tcm_arb: RTL and testbench

SCR1_TCM_ARB -- requirements
Module: scr1_tcm_arb

---
 rtl/scr1_tcm_arb.sv | 152 +++++++++++++++
 tb/tb_scr1_tcm_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_arb.sv
// Two-master arbiter for the TCM data port: round-robin grant, one outstanding
// slave access, same-cycle response routing, and timeout error completion.
module scr1_tcm_arb #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DWIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    output logic              m0_req_ack,
    input  logic              m0_cmd,
    input  logic [1:0]        m0_width,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic [1:0]        m0_resp,

    input  logic              m1_req,
    output logic              m1_req_ack,
    input  logic              m1_cmd,
    input  logic [1:0]        m1_width,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [1:0]        m1_resp,

    output logic              s_req,
    input  logic              s_req_ack,
    output logic              s_cmd,
    output logic [1:0]        s_width,
    output logic [AWIDTH-1:0] s_addr,
    output logic [DWIDTH-1:0] s_wdata,
    input  logic [DWIDTH-1:0] s_rdata,
    input  logic [1:0]        s_resp
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_ER     = 2'b10;
    // The grant cycle is cycle 0 and the counter reads 0 in the first wait
    // cycle, so the error completion lands TIMEOUT_CYC-1 cycles after grant.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_WAIT1 = 2'd2
    } state_e;

    typedef struct packed {
        logic              cmd;
        logic [1:0]        width;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } req_t;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic             in_wait;
    logic             resp_rdy;
    logic             timeout;
    logic             done;
    logic             grant_ok;
    logic             gnt0;
    logic             gnt1;
    logic [1:0]       done_resp;
    logic [DWIDTH-1:0] done_rdata;
    req_t             m0_pl;
    req_t             m1_pl;
    req_t             s_pl;

    // Arbitration, slave mux, response routing and next-state logic
    always_comb begin
        in_wait      = (state_q != ST_IDLE);
        resp_rdy     = in_wait && (s_resp != RESP_NOTRDY);
        timeout      = in_wait && (s_resp == RESP_NOTRDY) && (wait_cnt_q == CNT_LAST);
        done         = resp_rdy || timeout;
        grant_ok     = (!in_wait || done) && s_req_ack && !rst;

        // On contention the master not recorded in last_grant wins
        gnt0         = grant_ok && m0_req && (!m1_req || last_grant_q);
        gnt1         = grant_ok && m1_req && (!m0_req || !last_grant_q);

        m0_pl        = '{cmd: m0_cmd, width: m0_width, addr: m0_addr, wdata: m0_wdata};
        m1_pl        = '{cmd: m1_cmd, width: m1_width, addr: m1_addr, wdata: m1_wdata};
        s_pl         = '0;
        if (gnt0) begin
            s_pl = m0_pl;
        end else if (gnt1) begin
            s_pl = m1_pl;
        end

        s_req        = gnt0 || gnt1;
        s_cmd        = s_pl.cmd;
        s_width      = s_pl.width;
        s_addr       = s_pl.addr;
        s_wdata      = s_pl.wdata;
        m0_req_ack   = gnt0;
        m1_req_ack   = gnt1;

        done_resp    = timeout ? RESP_ER : s_resp;
        done_rdata   = timeout ? '0 : s_rdata;

        m0_resp      = RESP_NOTRDY;
        m0_rdata     = '0;
        m1_resp      = RESP_NOTRDY;
        m1_rdata     = '0;
        if (done && (state_q == ST_WAIT0)) begin
            m0_resp  = done_resp;
            m0_rdata = done_rdata;
        end
        if (done && (state_q == ST_WAIT1)) begin
            m1_resp  = done_resp;
            m1_rdata = done_rdata;
        end

        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        if (gnt0) begin
            state_d      = ST_WAIT0;
            last_grant_d = 1'b0;
            wait_cnt_d   = '0;
        end else if (gnt1) begin
            state_d      = ST_WAIT1;
            last_grant_d = 1'b1;
            wait_cnt_d   = '0;
        end else if (done) begin
            state_d      = ST_IDLE;
            wait_cnt_d   = '0;
        end else if (in_wait) begin
            wait_cnt_d   = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Directed bench for scr1_tcm_arb: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_scr1_tcm_arb;

    localparam int unsigned T  = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_cmd = 1'b0, m1_req = 1'b0, m1_cmd = 1'b0;
    logic [1:0]    m0_width = 2'b0, m1_width = 2'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          s_req_ack = 1'b1;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_resp = 2'b0;

    logic          m0_req_ack, m1_req_ack, s_req, s_cmd;
    logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
    logic [1:0]    m0_resp, m1_resp, s_width;
    logic [AW-1:0] s_addr;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    scr1_tcm_arb #(.TIMEOUT_CYC(T), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .s_req(s_req), .s_req_ack(s_req_ack), .s_cmd(s_cmd), .s_width(s_width),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: owner of the outstanding access (-1 none), cycles since its grant,
    // and the master that won the most recent grant.
    int owner = -1;
    int age   = 0;
    int last  = 1;
    int exp_win = -1;
    logic exp_done = 1'b0;

    always @(negedge clk) begin
        logic [1:0]    eresp;
        logic [DW-1:0] erdata;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewdata;
        logic [1:0]    ewidth;
        logic          ecmd;
        exp_done = (owner >= 0) && (s_resp != 2'b00 || age == int'(T) - 1);
        exp_win  = -1;
        if (!rst && s_req_ack && (owner < 0 || exp_done)) begin
            if (m0_req && m1_req) exp_win = (last == 0) ? 1 : 0;
            else if (m0_req)      exp_win = 0;
            else if (m1_req)      exp_win = 1;
        end
        eresp  = 2'b00;
        erdata = '0;
        if (exp_done) begin
            eresp  = (s_resp != 2'b00) ? s_resp : 2'b10;
            erdata = (s_resp != 2'b00) ? s_rdata : '0;
        end
        ecmd = 1'b0; ewidth = 2'b0; eaddr = '0; ewdata = '0;
        if (exp_win == 0) begin
            ecmd = m0_cmd; ewidth = m0_width; eaddr = m0_addr; ewdata = m0_wdata;
        end else if (exp_win == 1) begin
            ecmd = m1_cmd; ewidth = m1_width; eaddr = m1_addr; ewdata = m1_wdata;
        end
        if (chk_on) begin
            chk("m0_req_ack", 64'(m0_req_ack), 64'(exp_win == 0));
            chk("m1_req_ack", 64'(m1_req_ack), 64'(exp_win == 1));
            chk("s_req",      64'(s_req),      64'(exp_win >= 0));
            chk("s_cmd",      64'(s_cmd),      64'(ecmd));
            chk("s_width",    64'(s_width),    64'(ewidth));
            chk("s_addr",     64'(s_addr),     64'(eaddr));
            chk("s_wdata",    64'(s_wdata),    64'(ewdata));
            chk("m0_resp",    64'(m0_resp),    64'((owner == 0) ? eresp : 2'b00));
            chk("m0_rdata",   64'(m0_rdata),   64'((owner == 0) ? erdata : '0));
            chk("m1_resp",    64'(m1_resp),    64'((owner == 1) ? eresp : 2'b00));
            chk("m1_rdata",   64'(m1_rdata),   64'((owner == 1) ? erdata : '0));
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1;
            age   = 0;
            last  = 1;
        end else if (exp_win >= 0) begin
            owner = exp_win;
            age   = 1;
            last  = exp_win;
        end else if (exp_done) begin
            owner = -1;
        end else if (owner >= 0) begin
            age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_cmd = 1'b0; m1_cmd = 1'b0; m0_width = 2'b0; m1_width = 2'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        s_req_ack = 1'b1; s_resp = 2'b00; s_rdata = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle_in();
        sample();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        // Requests during reset are never acknowledged
        m0_req = 1'b1; m1_req = 1'b1;
        sample();
        chk("rst_m0_req_ack", 64'(m0_req_ack), 64'(0));
        chk("rst_s_req",      64'(s_req),      64'(0));
        tick();
        rst = 1'b0;
        idle_in();
        sample();

        // Single-master read
        tick();
        m0_req = 1'b1; m0_addr = 32'h100; m0_width = 2'b10;
        sample();
        chk("rd_ack",  64'(m0_req_ack), 64'(1));
        chk("rd_addr", 64'(s_addr),     64'h100);
        tick();
        idle_in();
        s_resp = 2'b01; s_rdata = 32'hDEADBEEF;
        sample();
        chk("rd_resp",    64'(m0_resp),  64'(1));
        chk("rd_rdata",   64'(m0_rdata), 64'hDEADBEEF);
        chk("rd_m1_resp", 64'(m1_resp),  64'(0));
        tick();
        idle_in();

        // Contention straight after reset: m0, m1, m0, m1
        do_reset();
        for (int k = 0; k < 5; k++) begin
            m0_req = (k < 4); m1_req = (k < 4);
            m0_addr = 32'h200 + 32'(k); m1_addr = 32'h300 + 32'(k);
            s_resp = (k > 0) ? 2'b01 : 2'b00;
            s_rdata = 32'h1000 + 32'(k);
            sample();
            if (k < 4) begin
                chk("ct_m0_ack", 64'(m0_req_ack), 64'(k % 2 == 0));
                chk("ct_m1_ack", 64'(m1_req_ack), 64'(k % 2 == 1));
            end
            if (k > 0) begin
                if ((k - 1) % 2 == 0) chk("ct_m0_rdata", 64'(m0_rdata), 64'h1000 + 64'(k));
                else                  chk("ct_m1_rdata", 64'(m1_rdata), 64'h1000 + 64'(k));
            end
            tick();
        end
        idle_in();

        // Timeout on an m1 write, then a late response in IDLE
        tick();
        m1_req = 1'b1; m1_cmd = 1'b1; m1_width = 2'b10; m1_addr = 32'h40; m1_wdata = 32'h55;
        sample();
        chk("to_ack", 64'(m1_req_ack), 64'(1));
        for (int k = 1; k <= 16; k++) begin
            tick();
            idle_in();
            if (k == 16) begin
                s_resp = 2'b01; s_rdata = 32'hBAD;
            end
            sample();
            if (k == 15 || k == 16) chk("to_m1_resp", 64'(m1_resp), 64'((k == 15) ? 2 : 0));
        end
        chk("late_m0_resp", 64'(m0_resp), 64'(0));
        tick();
        idle_in();

        // Back-pressure holds the grant off for three cycles
        for (int k = 0; k < 4; k++) begin
            m0_req = 1'b1; m0_addr = 32'h500; s_req_ack = (k == 3);
            sample();
            chk("bp_ack",   64'(m0_req_ack), 64'(k == 3));
            chk("bp_s_req", 64'(s_req),      64'(k == 3));
            tick();
        end
        idle_in();
        s_resp = 2'b01; s_rdata = 32'h77;
        sample();
        tick();
        idle_in();

        // Reset while m0 is outstanding; pending response is discarded
        m0_req = 1'b1; m0_addr = 32'h600;
        sample();
        tick();
        idle_in();
        sample();
        tick();
        rst = 1'b1; s_resp = 2'b01; s_rdata = 32'hCAFE; m0_req = 1'b1;
        #1;
        chk("mr_m0_resp",  64'(m0_resp),    64'(0));
        chk("mr_m0_rdata", 64'(m0_rdata),   64'(0));
        chk("mr_s_req",    64'(s_req),      64'(0));
        chk("mr_ack",      64'(m0_req_ack), 64'(0));
        sample();
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h700; m1_addr = 32'h800;
        sample();
        chk("mr_win_m0",   64'(m0_req_ack), 64'(1));
        chk("mr_lose_m1",  64'(m1_req_ack), 64'(0));
        chk("mr_discard",  64'(m0_resp),    64'(0));
        tick();
        idle_in();
        s_resp = 2'b01; s_rdata = 32'h123;
        sample();
        tick();
        idle_in();

        // Byte write from m1
        m1_req = 1'b1; m1_cmd = 1'b1; m1_width = 2'b00; m1_addr = 32'h3; m1_wdata = 32'hA5;
        sample();
        chk("bw_width", 64'(s_width), 64'(0));
        chk("bw_addr",  64'(s_addr),  64'h3);
        chk("bw_wdata", 64'(s_wdata), 64'hA5);
        chk("bw_cmd",   64'(s_cmd),   64'(1));
        tick();
        idle_in();
        s_resp = 2'b01;
        sample();
        chk("bw_resp",  64'(m1_resp), 64'(1));
        tick();
        idle_in();
        for (int k = 0; k < 3; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
